issue_req_tracker: RTL
======================

Name: issue_req_tracker

Overview:
- Requester-side partner of the multi-grant priority selector. Holds WIDTH issue-queue entries and tracks two source operands per entry.
- Drives the selector's req vector from entries whose operands are both ready.
- Consumes the returned multi-hot gnt vector: retires the granted entries and encodes them into NUM_GNTS registered issue slots for the functional-unit pipeline.
- Sits between dispatch/CDB wakeup and the selector/FU issue stage.

Parameters:
- WIDTH, 16, number of entries (req/gnt vector width).
- NUM_GNTS, 3, max grants consumed per cycle (issue slots).
- TAG_W, 6, physical register tag width.
- IDX_W, $clog2(WIDTH), entry index width (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- alloc_en  in  1  write one entry this cycle.
- alloc_idx  in  IDX_W  target entry.
- alloc_tag1, alloc_tag2  in  TAG_W each  source tags.
- alloc_rdy1, alloc_rdy2  in  1 each  source already ready at dispatch.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- stall  in  1  issue stage cannot accept; grants ignored this cycle.
- gnt  in  WIDTH  multi-hot grant from selector.
- req  out  WIDTH  request vector to selector (combinational from state).
- free  out  WIDTH  bit i = entry i invalid.
- count  out  IDX_W+1  registered number of valid entries.
- alloc_err  out  1  registered pulse: alloc_en to an entry that is valid and not being retired.
- issue_valid  out  NUM_GNTS  registered slot valid.
- issue_idx  out  NUM_GNTS*IDX_W  slot k in bits [k*IDX_W +: IDX_W].

Behaviour:
- Reset (reset==0 at posedge):
  - all entries invalid, both ready bits cleared.
  - count=0, alloc_err=0, issue_valid=0, issue_idx=0.
  - reset overrides every concurrent alloc, gnt and cdb event.
- Combinational outputs:
  - req[i] = valid[i] & rdy1[i] & rdy2[i].
  - free[i] = ~valid[i].
- Effective grant: eg = gnt & req.
  - Stray gnt bits on non-requesting entries are ignored.
  - eg is forced to 0 when stall=1.
- Grant consumption, slot ordering matches selector priority (highest index first):
  - slot 0 = highest set bit of eg; slot 1 = next highest; and so on.
  - At most NUM_GNTS bits are consumed. Lower extra bits are not cleared and their entries keep requesting.
- Issue latency: the consumed indices appear on issue_idx/issue_valid one cycle after the gnt edge.
  - Unused slots get issue_valid=0 and issue_idx=0.
  - When stall=1: issue_valid=0 next cycle and no entry changes.
- Retire: each consumed entry's valid bit clears at the same edge.
- Wakeup at posedge when cdb_valid=1: any valid entry with tagN==cdb_tag sets rdyN. Both sources may match at once.
- Allocation at posedge when alloc_en=1:
  - writes tags and valid=1.
  - rdyN = alloc_rdyN | (cdb_valid & cdb_tag==alloc_tagN), so a same-cycle CDB wakeup is not lost.
- Alloc to an entry retired by a grant in the same cycle is legal: retire first, then write. Entry ends valid with new contents and alloc_err=0.
- Alloc to a valid, non-retiring entry: write suppressed, alloc_err=1 for one cycle.
- count_next = count - (number consumed) + (successful alloc). It never wraps; reaches WIDTH when full.
- Entries are not ordered by age; priority is purely by index, as in the selector.

Test Plan:
- Reset: hold reset=0 with alloc_en=1 and gnt=all ones → after release, count=0, req=0, free=16'hFFFF, issue_valid=0.
- Alloc idx 5 (rdy1=1, rdy2=0, tag2=9); next cycle cdb_valid=1, cdb_tag=9 → req[5]=1 one cycle after the CDB edge.
- Entries 2, 7, 12, 14 ready; gnt=16'h5084 (bits 14, 12, 7, 2) → next cycle issue_idx slots = 14, 12, 7 with issue_valid=3'b111. Entry 2 stays valid with req[2]=1; count drops by 3.
- Same ready set with stall=1 and any gnt → issue_valid=0 and req unchanged; count unchanged.
- alloc_en idx 3 with alloc_tag1=cdb_tag=4, cdb_valid=1, alloc_rdy1=0, alloc_rdy2=1 → req[3]=1 on the next cycle.
- Entry 6 valid and ready; same cycle gnt[6]=1 and alloc idx 6 → issue slot 0 = 6, entry 6 valid with new tags, alloc_err=0, count unchanged. Repeat the alloc without a grant → alloc_err=1 for one cycle and contents preserved.

Source files
------------

// File: rtl/issue_req_tracker.sv
// Issue-queue requester: tracks operand readiness per entry, drives the
// selector's req vector, and turns the returned multi-hot grant into up to
// NUM_GNTS registered issue slots (highest index first).
module issue_req_tracker #(
    parameter int WIDTH    = 16,
    parameter int NUM_GNTS = 3,
    parameter int TAG_W    = 6,
    parameter int IDX_W    = $clog2(WIDTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alloc_en,
    input  logic [IDX_W-1:0]          alloc_idx,
    input  logic [TAG_W-1:0]          alloc_tag1,
    input  logic [TAG_W-1:0]          alloc_tag2,
    input  logic                      alloc_rdy1,
    input  logic                      alloc_rdy2,
    input  logic                      cdb_valid,
    input  logic [TAG_W-1:0]          cdb_tag,
    input  logic                      stall,
    input  logic [WIDTH-1:0]          gnt,
    output logic [WIDTH-1:0]          req,
    output logic [WIDTH-1:0]          free,
    output logic [IDX_W:0]            count,
    output logic                      alloc_err,
    output logic [NUM_GNTS-1:0]       issue_valid,
    output logic [NUM_GNTS*IDX_W-1:0] issue_idx
);

    logic [WIDTH-1:0]             valid, rdy1, rdy2;
    logic [WIDTH-1:0][TAG_W-1:0]  tag1, tag2;

    logic [WIDTH-1:0]             eg, rem, consumed;
    logic [NUM_GNTS-1:0]          slot_vld;
    logic [NUM_GNTS*IDX_W-1:0]    slot_idx;
    logic [IDX_W-1:0]             pick;
    logic                         found;
    logic [IDX_W:0]               num_cons;
    logic                         alloc_ok;

    assign req  = valid & rdy1 & rdy2;
    assign free = ~valid;
    // Grants only count on requesting entries, and nothing issues under stall.
    assign eg   = stall ? '0 : (gnt & req);

    // Peel off the highest remaining grant bit once per slot; leftovers stay requesting.
    always_comb begin
        rem      = eg;
        consumed = '0;
        slot_vld = '0;
        slot_idx = '0;
        pick     = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_GNTS; k++) begin
            found = 1'b0;
            pick  = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (rem[i]) begin
                    found = 1'b1;
                    pick  = IDX_W'(i);
                end
            end
            if (found) begin
                slot_vld[k]                 = 1'b1;
                slot_idx[k*IDX_W +: IDX_W]  = pick;
                rem[pick]                   = 1'b0;
                consumed[pick]              = 1'b1;
            end
        end
    end

    // Number of entries retiring this cycle, and whether the alloc may write.
    always_comb begin
        num_cons = '0;
        for (int i = 0; i < WIDTH; i++)
            num_cons = num_cons + (IDX_W+1)'(consumed[i]);
        // A slot freed by this cycle's grant may be refilled in the same edge.
        alloc_ok = alloc_en & (~valid[alloc_idx] | consumed[alloc_idx]);
    end

    // Entry state: retire, CDB wakeup, then allocation (alloc wins on its own entry).
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= '0;
            rdy1  <= '0;
            rdy2  <= '0;
            tag1  <= '0;
            tag2  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (consumed[i])
                    valid[i] <= 1'b0;
                if (cdb_valid && valid[i] && tag1[i] == cdb_tag)
                    rdy1[i] <= 1'b1;
                if (cdb_valid && valid[i] && tag2[i] == cdb_tag)
                    rdy2[i] <= 1'b1;
                if (alloc_ok && alloc_idx == IDX_W'(i)) begin
                    valid[i] <= 1'b1;
                    tag1[i]  <= alloc_tag1;
                    tag2[i]  <= alloc_tag2;
                    // Catch a wakeup broadcast in the same cycle as dispatch.
                    rdy1[i]  <= alloc_rdy1 | (cdb_valid && cdb_tag == alloc_tag1);
                    rdy2[i]  <= alloc_rdy2 | (cdb_valid && cdb_tag == alloc_tag2);
                end
            end
        end
    end

    // Registered occupancy, alloc error pulse and issue slots.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count       <= '0;
            alloc_err   <= 1'b0;
            issue_valid <= '0;
            issue_idx   <= '0;
        end else begin
            count       <= count - num_cons + (IDX_W+1)'(alloc_ok);
            alloc_err   <= alloc_en & ~alloc_ok;
            issue_valid <= slot_vld;
            issue_idx   <= slot_idx;
        end
    end

endmodule
